// File: rtl/actuador_compuertas.sv
// actuador_compuertas: turns the classifier's one-hot grade LEDs into a timed
// diverter-gate pulse. A grade must be seen unchanged for STABLE_CYC samples.
// Each pulse or error is followed by a gate-closed recovery gap. The block also
// keeps saturating per-grade and error tallies, readable through cnt_sel.
//
// There is no valid/ready handshake here. The inputs are free-running levels.
// A new grade is taken only while the FSM is in IDLE or QUALIFY. In OPEN the
// inputs are ignored. In GAP the inputs are only watched for the 0 sample that
// re-arms the block.
module actuador_compuertas #(
    parameter int STABLE_CYC = 4,
    parameter int GATE_CYC   = 16,
    parameter int GAP_CYC    = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             led_baja,
    input  logic             led_media,
    input  logic             led_alta,
    input  logic             clr_cnt,
    input  logic [1:0]       cnt_sel,
    output logic             gate_baja,
    output logic             gate_media,
    output logic             gate_alta,
    output logic             busy,
    output logic             error,
    output logic [CNT_W-1:0] cnt_out
);

    localparam int SW   = $clog2(STABLE_CYC);
    localparam int TMAX = (GATE_CYC > GAP_CYC) ? GATE_CYC : GAP_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [SW-1:0]    STAB_ONE  = SW'(1);
    localparam logic [SW-1:0]    STAB_LAST = SW'(STABLE_CYC - 1);
    localparam logic [TW-1:0]    TMR_ONE   = TW'(1);
    localparam logic [TW-1:0]    GATE_LOAD = TW'(GATE_CYC - 1);
    localparam logic [TW-1:0]    GAP_LOAD  = TW'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_QUALIFY = 2'd1,
        S_OPEN    = 2'd2,
        S_GAP     = 2'd3
    } state_t;

    // state is left visible by name so that checkers can reach it hierarchically
    state_t           state;
    logic [2:0]       v;
    logic [2:0]       candidate;
    logic [SW-1:0]    stab;
    logic [TW-1:0]    timer;
    logic [2:0]       gates;
    logic [CNT_W-1:0] cnt_baja;
    logic [CNT_W-1:0] cnt_media;
    logic [CNT_W-1:0] cnt_alta;
    logic [CNT_W-1:0] cnt_err;

    assign v          = {led_alta, led_media, led_baja};
    assign gate_baja  = gates[0];
    assign gate_media = gates[1];
    assign gate_alta  = gates[2];

    function automatic logic is_onehot(input logic [2:0] c);
        return (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_ONE;
    endfunction

    // Sequencing, gate drive, tallies. clr_cnt is applied last, so it overrides a same-edge increment
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            gates     <= 3'b000;
            busy      <= 1'b0;
            error     <= 1'b0;
            candidate <= 3'b000;
            stab      <= '0;
            timer     <= '0;
            cnt_baja  <= '0;
            cnt_media <= '0;
            cnt_alta  <= '0;
            cnt_err   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (v != 3'b000) begin
                        candidate <= v;
                        stab      <= STAB_ONE;
                        state     <= S_QUALIFY;
                    end
                end
                S_QUALIFY: begin
                    if (v == 3'b000) begin
                        state <= S_IDLE;
                    end else if (v != candidate) begin
                        candidate <= v;
                        stab      <= STAB_ONE;
                    end else if (stab != STAB_LAST) begin
                        stab <= stab + STAB_ONE;
                    end else if (is_onehot(candidate)) begin
                        state <= S_OPEN;
                        gates <= candidate;
                        busy  <= 1'b1;
                        timer <= GATE_LOAD;
                        if (candidate[0])      cnt_baja  <= sat_inc(cnt_baja);
                        else if (candidate[1]) cnt_media <= sat_inc(cnt_media);
                        else                   cnt_alta  <= sat_inc(cnt_alta);
                    end else begin
                        // A stable multi-hot code is a classifier fault, so no gate fires
                        error   <= 1'b1;
                        cnt_err <= sat_inc(cnt_err);
                        state   <= S_GAP;
                        busy    <= 1'b1;
                        timer   <= GAP_LOAD;
                    end
                end
                S_OPEN: begin
                    if (timer == '0) begin
                        gates <= 3'b000;
                        state <= S_GAP;
                        timer <= GAP_LOAD;
                    end else begin
                        timer <= timer - TMR_ONE;
                    end
                end
                S_GAP: begin
                    // Leave only on a 0 sample, so a held grade cannot retrigger
                    if (timer != '0) begin
                        timer <= timer - TMR_ONE;
                    end else if (v == 3'b000) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    gates <= 3'b000;
                    busy  <= 1'b0;
                end
            endcase
            if (clr_cnt) begin
                cnt_baja  <= '0;
                cnt_media <= '0;
                cnt_alta  <= '0;
                cnt_err   <= '0;
                error     <= 1'b0;
            end
        end
    end

    // Zero-latency readout of the selected tally
    always_comb begin
        cnt_out = '0;
        case (cnt_sel)
            2'd0:    cnt_out = cnt_baja;
            2'd1:    cnt_out = cnt_media;
            2'd2:    cnt_out = cnt_alta;
            default: cnt_out = cnt_err;
        endcase
    end

endmodule

// File: tb/tb_actuador_compuertas.sv
// Bench for actuador_compuertas: the directed driver pushes expected gate
// pulses {code, length, rise cycle} into exp_q. A monitor pops an entry and
// compares it whenever a gate pulse ends. Tallies and flags are checked
// directly against hand-computed values.
module tb_actuador_compuertas;

    localparam int EW = 43;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  v = 3'b000;
    logic        clr_cnt = 1'b0;
    logic [1:0]  cnt_sel = 2'd0;
    logic        gate_baja, gate_media, gate_alta, busy, error;
    logic [7:0]  cnt_out;

    logic [2:0]  v2 = 3'b000;
    logic [1:0]  cnt_sel2 = 2'd0;
    logic        gate_baja2, gate_media2, gate_alta2, busy2, error2;
    logic [1:0]  cnt_out2;

    logic [EW-1:0] exp_q[$];
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    actuador_compuertas dut (
        .clk(clk), .reset(reset),
        .led_baja(v[0]), .led_media(v[1]), .led_alta(v[2]),
        .clr_cnt(clr_cnt), .cnt_sel(cnt_sel),
        .gate_baja(gate_baja), .gate_media(gate_media), .gate_alta(gate_alta),
        .busy(busy), .error(error), .cnt_out(cnt_out)
    );

    actuador_compuertas #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset),
        .led_baja(v2[0]), .led_media(v2[1]), .led_alta(v2[2]),
        .clr_cnt(1'b0), .cnt_sel(cnt_sel2),
        .gate_baja(gate_baja2), .gate_media(gate_media2), .gate_alta(gate_alta2),
        .busy(busy2), .error(error2), .cnt_out(cnt_out2)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_pulse(input logic [2:0] code, input int len, input int rise);
        exp_q.push_back({code, 8'(len), 32'(rise)});
    endtask

    task automatic check_cnt(input string name, input logic [1:0] sel, input logic [7:0] exp);
        cnt_sel = sel;
        #1;
        check(name, {56'd0, cnt_out}, {56'd0, exp});
    endtask

    task automatic print_summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    // monitor: one pulse = consecutive samples with any gate high
    initial begin : monitor
        logic [2:0]    g;
        logic [2:0]    pcode;
        int            plen;
        int            prise;
        bit            inp;
        logic [EW-1:0] e;
        inp = 1'b0; pcode = 3'b000; plen = 0; prise = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            g = {gate_alta, gate_media, gate_baja};
            if (!$isunknown(g)) begin
                if (!inp && g != 3'b000) begin
                    inp = 1'b1; pcode = g; plen = 1; prise = cyc;
                end else if (inp && g != 3'b000) begin
                    pcode = pcode | g;
                    plen++;
                end else if (inp) begin
                    inp = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL pulse: unexpected pulse code=%b len=%0d rise=%0d, none expected",
                                 pcode, plen, prise);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse{code,len,rise}", {21'd0, pcode, 8'(plen), 32'(prise)}, {21'd0, e});
                    end
                end
            end
        end
    end

    // watchdog
    initial begin
        #2_000_000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        print_summary();
        $finish;
    end

    // driver
    initial begin
        int k;
        logic [2:0] pat [3];
        pat[0] = 3'b111; pat[1] = 3'b010; pat[2] = 3'b101;

        // 1: reset with toggling inputs
        step(1);
        for (int i = 0; i < 3; i++) begin
            v = pat[i];
            step(1);
        end
        reset = 1'b0;
        v = 3'b000;
        check("rst_gates", {61'd0, gate_alta, gate_media, gate_baja}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_error", {63'd0, error}, 64'd0);
        for (int s = 0; s < 4; s++) check_cnt("rst_cnt", 2'(s), 8'd0);

        // 2: clean media bean, held 40 cycles
        step(2);
        k = cyc; v = 3'b010; push_pulse(3'b010, 16, k + 4);
        step(40);
        check("media_busy_held", {63'd0, busy}, 64'd1);
        check_cnt("media_cnt", 2'd1, 8'd1);
        v = 3'b000;
        step(1);
        check("media_busy_release", {63'd0, busy}, 64'd0);
        check_cnt("media_other_baja", 2'd0, 8'd0);
        check_cnt("media_other_alta", 2'd2, 8'd0);
        check_cnt("media_other_err", 2'd3, 8'd0);

        // 3a: alta glitch of 3 cycles
        step(2);
        v = 3'b100; step(3);
        v = 3'b000; step(10);
        check_cnt("glitch_alta_cnt", 2'd2, 8'd0);
        check("glitch_busy", {63'd0, busy}, 64'd0);

        // 3b: baja 2 cycles then alta 4 cycles
        v = 3'b001; step(2);
        k = cyc; v = 3'b100; push_pulse(3'b100, 16, k + 4);
        step(4);
        v = 3'b000; step(30);
        check_cnt("switch_alta_cnt", 2'd2, 8'd1);
        check_cnt("switch_baja_cnt", 2'd0, 8'd0);

        // 4: two-hot code -> error, no gate, wait for 0 to leave GAP
        v = 3'b101; step(10);
        check("err_flag", {63'd0, error}, 64'd1);
        check_cnt("err_cnt", 2'd3, 8'd1);
        check("err_busy", {63'd0, busy}, 64'd1);
        step(10);
        check("err_busy_held", {63'd0, busy}, 64'd1);
        v = 3'b000; step(1);
        check("err_busy_release", {63'd0, busy}, 64'd0);

        // clear all tallies and the error flag
        clr_cnt = 1'b1; step(1); clr_cnt = 1'b0;
        check("clr_error", {63'd0, error}, 64'd0);
        check_cnt("clr_err_cnt", 2'd3, 8'd0);
        check_cnt("clr_media_cnt", 2'd1, 8'd0);
        check_cnt("clr_alta_cnt", 2'd2, 8'd0);

        // 5: held alta gives one pulse; a 1-cycle drop re-arms
        step(2);
        k = cyc; v = 3'b100; push_pulse(3'b100, 16, k + 4);
        step(100);
        check("held_busy", {63'd0, busy}, 64'd1);
        check_cnt("held_alta_cnt", 2'd2, 8'd1);
        v = 3'b000; step(1);
        k = cyc; v = 3'b100; push_pulse(3'b100, 16, k + 4);
        step(30);
        v = 3'b000; step(2);
        check_cnt("repeat_alta_cnt", 2'd2, 8'd2);

        // 6b: clr_cnt on the OPEN-entry edge
        step(2);
        k = cyc; v = 3'b010; push_pulse(3'b010, 16, k + 4);
        step(3);
        clr_cnt = 1'b1; step(1); clr_cnt = 1'b0;
        check("clr_entry_gate", {63'd0, gate_media}, 64'd1);
        check_cnt("clr_entry_cnt", 2'd1, 8'd0);
        step(20);
        v = 3'b000; step(10);
        check_cnt("clr_entry_cnt_after", 2'd1, 8'd0);
        check("clr_entry_idle", {63'd0, busy}, 64'd0);

        // 6c: reset on the 5th cycle of OPEN
        k = cyc; v = 3'b001; push_pulse(3'b001, 5, k + 4);
        step(8);
        check_cnt("pre_rst_baja_cnt", 2'd0, 8'd1);
        reset = 1'b1; step(1);
        check("rst_open_gate", {63'd0, gate_baja}, 64'd0);
        check("rst_open_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0; v = 3'b000;
        check_cnt("rst_open_cnt", 2'd0, 8'd0);
        step(3);

        // 6a: CNT_W=2 saturation on the second instance
        for (int b = 0; b < 5; b++) begin
            v2 = 3'b001; step(30);
            v2 = 3'b000; step(2);
            if (b == 1) check("sat_cnt_2", {62'd0, cnt_out2}, 64'd2);
        end
        check("sat_cnt_5", {62'd0, cnt_out2}, 64'd3);

        step(5);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        print_summary();
        $finish;
    end

endmodule

// File: doc/actuador_compuertas.md
Name: actuador_compuertas

Overview:
Downstream consumer of the coffee classifier's grade outputs (led_baja / led_media / led_alta).
- Qualifies each one-hot grade as a bean event, then drives the matching diverter gate for a fixed pulse.
- Enforces a mechanical recovery gap after each pulse and keeps per-grade and error counts.
- Counts are readable through a select mux, so the classifier's result becomes a physical sort plus tallies.

Parameters:
STABLE_CYC, 4, consecutive identical nonzero input samples required to accept a grade (>=2)
GATE_CYC, 16, cycles a gate output stays asserted per accepted bean (>=1)
GAP_CYC, 8, minimum cycles of gate-closed recovery after a pulse or an error (>=1)
CNT_W, 8, width of each saturating counter

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  synchronous, active-high reset
led_baja  in  1  low-grade indication from classifier (level)
led_media  in  1  medium-grade indication (level)
led_alta  in  1  high-grade indication (level)
clr_cnt  in  1  synchronous clear of all counters and the error flag
cnt_sel  in  2  counter select: 0 baja, 1 media, 2 alta, 3 error
gate_baja  out  1  low-grade diverter drive, registered
gate_media  out  1  medium-grade diverter drive, registered
gate_alta  out  1  high-grade diverter drive, registered
busy  out  1  high in OPEN and GAP
error  out  1  sticky: set on a non-one-hot qualified code
cnt_out  out  CNT_W  selected counter value, combinational mux of the counter registers

Behaviour:
- Reset (sync, active-high): state IDLE; all gates 0; busy 0; error 0; all counters 0; candidate 0. Reset mid-OPEN drops the gate at that same edge.
- Sampled input vector v = {led_alta, led_media, led_baja}.
- FSM states: IDLE, QUALIFY, OPEN, GAP.
- IDLE:
  - v==0: stay.
  - v!=0: capture candidate=v, stab=1, go QUALIFY.
- QUALIFY:
  - v==0: go IDLE.
  - v!=0 and v!=candidate: candidate=v, stab=1, stay.
  - v==candidate and stab<STABLE_CYC-1: stab++.
  - v==candidate and stab==STABLE_CYC-1, candidate one-hot: go OPEN, assert the matching gate at this edge, increment that grade counter.
  - v==candidate and stab==STABLE_CYC-1, candidate not one-hot: error=1, increment error counter, go GAP with timer loaded.
- OPEN: exactly one gate high for exactly GATE_CYC cycles. Inputs are ignored. Then the gate drops and the FSM goes to GAP.
- GAP:
  - All gates 0 for at least GAP_CYC cycles.
  - After GAP_CYC, stay in GAP until v==0; that single-cycle v==0 sample moves the FSM to IDLE.
  - A held grade therefore yields one pulse only.
- Latency: gate rises at the STABLE_CYC-th sampling edge after v first appears. With defaults: 4th edge, i.e. 3 edges after entering QUALIFY.
- Gates are mutually exclusive at all times. busy=1 exactly while in OPEN or GAP.
- Counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - clr_cnt clears all counters and error. clr_cnt wins over a same-cycle increment or error set. clr_cnt does not disturb FSM or gates.
- cnt_out follows cnt_sel with zero latency.

Test Plan:
1. Assert reset 3 cycles while inputs toggle -> gates/busy/error=0; cnt_out=0 for every cnt_sel.
2. led_media=1 for 40 cycles, then 0 -> gate_media high exactly 16 cycles, rising on the 4th sampling edge. busy high for 16+GAP (>=8) cycles, returns 0 after the input falls. cnt_sel=1 gives cnt_out=1; other counters 0.
3. Glitches:
   - led_alta=1 for 3 cycles only -> no gate, all counts 0.
   - led_baja 2 cycles then led_alta 4 cycles -> single gate_alta pulse, alta count=1.
4. led_baja=1 and led_alta=1 together for 10 cycles -> no gate, error=1, error count (sel=3)=1, FSM returns to IDLE only after inputs reach 0.
5. Held and repeated grades:
   - led_alta held 100 cycles -> exactly one 16-cycle pulse, alta count=1.
   - Drop for 1 cycle, reassert -> second pulse, count=2.
6. Boundaries:
   - CNT_W=2: 5 accepted baja beans -> cnt_out=3.
   - clr_cnt on the OPEN-entry edge -> count reads 0 and the gate pulse still completes.
   - reset at cycle 5 of OPEN -> gate 0 from that edge.
